// File: rtl/aes_pkg.sv
// Shared AES types and the inverse S-box lookup for the decryption datapath.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    localparam int AES_NB_BYTES = 16;

    localparam aes_byte_t INV_SBOX_TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_byte_t inv_sbox(aes_byte_t b);
        return INV_SBOX_TBL[b];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// One combinational AES inverse S-box lane (8-bit in, 8-bit out).
module inv_sbox (
    input  aes_pkg::aes_byte_t value,
    output aes_pkg::aes_byte_t result
);

    // Scoped call: the module shares its name with the package function.
    assign result = aes_pkg::inv_sbox(value);

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock through a shared S-box bank.
// Optional block counter output enabled by defining INV_SUB_BYTES_STATS_EN.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t state_in,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t state_out
`ifdef INV_SUB_BYTES_STATS_EN
    ,
    output logic [31:0] blk_count
`endif
);

    localparam int N     = AES_NB_BYTES / BYTES_PER_CYCLE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int GRP_W = 8 * BYTES_PER_CYCLE;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_cfg
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    // Group 0 is the MSB group, so the group index walks bytes 0..15 in order.
    logic [0:N-1][GRP_W-1:0] work_q, work_sub;
    logic [GRP_W-1:0]        grp_cur, grp_sub;
    aes_byte_t               lane_in  [BYTES_PER_CYCLE];
    aes_byte_t               lane_out [BYTES_PER_CYCLE];
    logic                    load, step, finish;

    if (N == 1) begin : g_single_grp
        assign grp_cur  = work_q[0];
        assign work_sub = grp_sub;
    end else begin : g_multi_grp
        assign grp_cur = work_q[idx_q];
        always_comb begin
            work_sub        = work_q;
            work_sub[idx_q] = grp_sub;
        end
    end

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        assign lane_in[l] = grp_cur[GRP_W-1-8*l -: 8];
        inv_sbox u_inv_sbox (
            .value  (lane_in[l]),
            .result (lane_out[l])
        );
    end

    always_comb begin
        grp_sub = '0;
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            grp_sub[GRP_W-1-8*l -: 8] = lane_out[l];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (idx_q == IDX_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            work_q    <= '0;
            state_out <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                work_q <= state_in;
                idx_q  <= '0;
            end else if (step) begin
                work_q <= work_sub;
                // Hold idx at the last group rather than wrapping.
                if (!finish) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (finish) begin
                state_out <= work_sub;
            end
        end
    end

`ifdef INV_SUB_BYTES_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= '0;
        end else if (out_valid && out_ready) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif

endmodule
